// File: rtl/kt8_pkg.sv
// Shared constants and FSM encoding for the KT8 RAM arbiter.
package kt8_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2
   } state_t;

endpackage

// File: rtl/kt8_rr_arb2.sv
// Combinational two-way grant. The last-served pointer is held by the parent.
// With KT8_ARB_FIXED_PRIO_EN defined, port 0 always wins and the pointer input is removed.
module kt8_rr_arb2 (
   input  logic req0,
   input  logic req1,
`ifndef KT8_ARB_FIXED_PRIO_EN
   input  logic last_id,
`endif
   output logic gnt_valid,
   output logic gnt_id
);

   // grant selection: a lone request wins, a tie goes to the port not served last
   always_comb begin
      gnt_valid = req0 | req1;
      gnt_id    = 1'b0;
      if (req0 && req1) begin
`ifdef KT8_ARB_FIXED_PRIO_EN
         gnt_id = 1'b0;
`else
         gnt_id = ~last_id;
`endif
      end else if (req1) begin
         gnt_id = 1'b1;
      end else begin
         gnt_id = 1'b0;
      end
   end

endmodule

// File: rtl/kt8_ram_arb.sv
// Two-port req/ack sequencer in front of the KT8 16x8 RAM (IDLE -> ACCESS -> ACK).
// Define KT8_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module kt8_ram_arb
   import kt8_pkg::*;
#(
   parameter int ADDR_W = kt8_pkg::ADDR_W,
   parameter int DATA_W = kt8_pkg::DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req0_i,
   input  logic              we0_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [DATA_W-1:0] wdata0_i,
   output logic              ack0_o,
   output logic [DATA_W-1:0] rdata0_o,
   input  logic              req1_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata1_i,
   output logic              ack1_o,
   output logic [DATA_W-1:0] rdata1_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_din_o,
   output logic              ram_we_o,
   input  logic [DATA_W-1:0] ram_dout_i,
   output logic              busy_o
);

   state_t            state_r;
   state_t            state_nxt_s;
   logic              gnt_valid_s;
   logic              gnt_id_s;
   logic              id_r;
   logic              we_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic              ack0_r;
   logic              ack1_r;
   logic [DATA_W-1:0] rdata0_r;
   logic [DATA_W-1:0] rdata1_r;

`ifdef KT8_ARB_FIXED_PRIO_EN
   kt8_rr_arb2 u_arb (
      .req0      (req0_i),
      .req1      (req1_i),
      .gnt_valid (gnt_valid_s),
      .gnt_id    (gnt_id_s)
   );
`else
   logic last_r;

   kt8_rr_arb2 u_arb (
      .req0      (req0_i),
      .req1      (req1_i),
      .last_id   (last_r),
      .gnt_valid (gnt_valid_s),
      .gnt_id    (gnt_id_s)
   );

   // last-served pointer; reset value 1 lets port 0 win the first tie
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_r <= 1'b1;
      end else if (state_r == ST_IDLE && gnt_valid_s) begin
         last_r <= gnt_id_s;
      end else begin
         last_r <= last_r;
      end
   end
`endif

   // next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (gnt_valid_s) begin
               state_nxt_s = ST_ACCESS;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACCESS: state_nxt_s = ST_ACK;
         ST_ACK:    state_nxt_s = ST_IDLE;
         default:   state_nxt_s = ST_IDLE;
      endcase
   end

   // state, latched request, acks and per-port read data
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r  <= ST_IDLE;
         id_r     <= 1'b0;
         we_r     <= 1'b0;
         addr_r   <= {ADDR_W{1'b0}};
         wdata_r  <= {DATA_W{1'b0}};
         ack0_r   <= 1'b0;
         ack1_r   <= 1'b0;
         rdata0_r <= {DATA_W{1'b0}};
         rdata1_r <= {DATA_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         ack0_r  <= 1'b0;
         ack1_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (gnt_valid_s) begin
                  id_r    <= gnt_id_s;
                  we_r    <= gnt_id_s ? we1_i    : we0_i;
                  addr_r  <= gnt_id_s ? addr1_i  : addr0_i;
                  wdata_r <= gnt_id_s ? wdata1_i : wdata0_i;
               end
            end
            ST_ACCESS: begin
               if (id_r) begin
                  ack1_r <= 1'b1;
               end else begin
                  ack0_r <= 1'b1;
               end
               // a read lands only in the granted port's register; writes leave rdata alone
               if (!we_r && id_r) begin
                  rdata1_r <= ram_dout_i;
               end else if (!we_r) begin
                  rdata0_r <= ram_dout_i;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // reset is folded in combinationally so an access cut short by reset never writes
   assign ram_we_o   = (state_r == ST_ACCESS) & we_r & ~rst_i;
   assign ram_addr_o = addr_r;
   assign ram_din_o  = wdata_r;
   assign ack0_o     = ack0_r;
   assign ack1_o     = ack1_r;
   assign rdata0_o   = rdata0_r;
   assign rdata1_o   = rdata1_r;
   assign busy_o     = (state_r != ST_IDLE);

endmodule

// File: tb/tb_kt8_ram_arb.sv
// Directed bench for kt8_ram_arb with a behavioural 16x8 RAM (async read, posedge write).
module tb_kt8_ram_arb;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       req0_i = 1'b0, we0_i = 1'b0, req1_i = 1'b0, we1_i = 1'b0;
   logic [3:0] addr0_i = 4'd0, addr1_i = 4'd0;
   logic [7:0] wdata0_i = 8'd0, wdata1_i = 8'd0;
   logic       ack0_o, ack1_o, ram_we_o, busy_o;
   logic [7:0] rdata0_o, rdata1_o, ram_din_o, ram_dout_i;
   logic [3:0] ram_addr_o;

   logic [7:0] mem [16];
   logic       pl_we = 1'b0;
   logic [3:0] pl_addr = 4'd0;
   logic [7:0] pl_data = 8'd0;
   int         we_cnt = 0;
   int         checks = 0;
   int         errors = 0;

   kt8_ram_arb dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i),
      .ack0_o(ack0_o), .rdata0_o(rdata0_o),
      .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
      .ack1_o(ack1_o), .rdata1_o(rdata1_o),
      .ram_addr_o(ram_addr_o), .ram_din_o(ram_din_o), .ram_we_o(ram_we_o),
      .ram_dout_i(ram_dout_i), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      if (ram_we_o) mem[ram_addr_o] <= ram_din_o;
      else if (pl_we) mem[pl_addr] <= pl_data;
   end
   assign ram_dout_i = mem[ram_addr_o];

   always @(negedge clk_i) if (ram_we_o) we_cnt <= we_cnt + 1;

   task automatic preload(input logic [3:0] a, input logic [7:0] d);
      pl_we = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk_i); #1;
      pl_we = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 16; i++) preload(i[3:0], 8'h00);
      preload(4'd1, 8'h11);
      preload(4'd2, 8'h22);
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      checks++; if (ack0_o !== 1'b0 || ack1_o !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b%b want 00", ack0_o, ack1_o); end
      checks++; if (rdata0_o !== 8'h00 || rdata1_o !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h/%h want 00/00", rdata0_o, rdata1_o); end
      checks++; if (ram_addr_o !== 4'd0 || ram_din_o !== 8'h00) begin errors++; $display("FAIL rst_ram_bus: got %h/%h want 0/00", ram_addr_o, ram_din_o); end
      checks++; if (ram_we_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rst_we_busy: got %b%b want 00", ram_we_o, busy_o); end
      rst_i = 1'b0;
   endtask

   task automatic test_write_read();
      int we0;
      we0 = we_cnt;
      req0_i = 1'b1; we0_i = 1'b1; addr0_i = 4'd3; wdata0_i = 8'hA5;
      @(posedge clk_i); #1;
      checks++; if (ram_we_o !== 1'b1 || ram_addr_o !== 4'd3 || ram_din_o !== 8'hA5) begin errors++; $display("FAIL wr_access: got we=%b a=%h d=%h want 1/3/a5", ram_we_o, ram_addr_o, ram_din_o); end
      checks++; if (ack0_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL wr_early_ack: got ack=%b busy=%b want 0/1", ack0_o, busy_o); end
      @(posedge clk_i); #1;
      checks++; if (ack0_o !== 1'b1 || ram_we_o !== 1'b0) begin errors++; $display("FAIL wr_ack: got ack=%b we=%b want 1/0", ack0_o, ram_we_o); end
      @(posedge clk_i); #1;
      checks++; if (ack0_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL wr_idle: got ack=%b busy=%b want 0/0", ack0_o, busy_o); end
      checks++; if (we_cnt - we0 != 1) begin errors++; $display("FAIL wr_we_pulses: got %0d want 1", we_cnt - we0); end
      we0_i = 1'b0;
      @(posedge clk_i); #1;
      checks++; if (ram_we_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL rd_access: got we=%b busy=%b want 0/1", ram_we_o, busy_o); end
      @(posedge clk_i); #1;
      checks++; if (ack0_o !== 1'b1 || rdata0_o !== 8'hA5) begin errors++; $display("FAIL rd_data: got ack=%b d=%h want 1/a5", ack0_o, rdata0_o); end
      @(posedge clk_i); #1;
      req0_i = 1'b0;
      checks++; if (ack0_o !== 1'b0 || rdata0_o !== 8'hA5) begin errors++; $display("FAIL rd_hold: got ack=%b d=%h want 0/a5", ack0_o, rdata0_o); end
   endtask

   task automatic test_contention();
      logic e0, e1;
      do_reset();
      req0_i = 1'b1; we0_i = 1'b0; addr0_i = 4'd1;
      req1_i = 1'b1; we1_i = 1'b0; addr1_i = 4'd2;
      for (int j = 0; j < 12; j++) begin
         @(posedge clk_i); #1;
         e0 = (j % 6 == 1);
         e1 = (j % 6 == 4);
         checks++; if (ack0_o !== e0 || ack1_o !== e1) begin errors++; $display("FAIL cont_ack[%0d]: got %b%b want %b%b", j, ack0_o, ack1_o, e0, e1); end
         checks++; if (busy_o !== (j % 3 != 2)) begin errors++; $display("FAIL cont_busy[%0d]: got %b want %b", j, busy_o, (j % 3 != 2)); end
         if (e0) begin
            checks++; if (rdata0_o !== 8'h11) begin errors++; $display("FAIL cont_rd0[%0d]: got %h want 11", j, rdata0_o); end
         end
         if (e1) begin
            checks++; if (rdata1_o !== 8'h22) begin errors++; $display("FAIL cont_rd1[%0d]: got %h want 22", j, rdata1_o); end
         end
      end
      req0_i = 1'b0; req1_i = 1'b0;
   endtask

   task automatic test_cross_port();
      req1_i = 1'b1; we1_i = 1'b1; addr1_i = 4'd15; wdata1_i = 8'h3C;
      @(posedge clk_i); #1;
      req0_i = 1'b1; we0_i = 1'b0; addr0_i = 4'd15;
      checks++; if (ram_we_o !== 1'b1 || ram_addr_o !== 4'd15) begin errors++; $display("FAIL xp_wr: got we=%b a=%h want 1/f", ram_we_o, ram_addr_o); end
      @(posedge clk_i); #1;
      checks++; if (ack1_o !== 1'b1 || ack0_o !== 1'b0 || rdata1_o !== 8'h22) begin errors++; $display("FAIL xp_ack1: got %b%b rd1=%h want 01/22", ack0_o, ack1_o, rdata1_o); end
      @(posedge clk_i); #1;
      req1_i = 1'b0;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      checks++; if (ack0_o !== 1'b1 || rdata0_o !== 8'h3C) begin errors++; $display("FAIL xp_rd0: got ack=%b d=%h want 1/3c", ack0_o, rdata0_o); end
      @(posedge clk_i); #1;
      req0_i = 1'b0;
   endtask

   task automatic test_reset_mid_write();
      int we0;
      we0 = we_cnt;
      req0_i = 1'b1; we0_i = 1'b1; addr0_i = 4'd7; wdata0_i = 8'hFF;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      #1;
      checks++; if (ram_we_o !== 1'b0) begin errors++; $display("FAIL rmw_we_gate: got %b want 0", ram_we_o); end
      @(posedge clk_i); #1;
      rst_i = 1'b0; req0_i = 1'b0;
      for (int j = 0; j < 3; j++) begin
         checks++; if (ack0_o !== 1'b0 || busy_o !== (j == 0 ? 1'b0 : busy_o)) begin errors++; $display("FAIL rmw_noack[%0d]: got ack=%b busy=%b want 0/0", j, ack0_o, busy_o); end
         @(posedge clk_i); #1;
      end
      checks++; if (mem[7] !== 8'h00 || we_cnt != we0) begin errors++; $display("FAIL rmw_mem: got %h pulses=%0d want 00/0", mem[7], we_cnt - we0); end
      req0_i = 1'b1; we0_i = 1'b0; addr0_i = 4'd7;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      checks++; if (ack0_o !== 1'b1 || rdata0_o !== 8'h00) begin errors++; $display("FAIL rmw_read: got ack=%b d=%h want 1/00", ack0_o, rdata0_o); end
      @(posedge clk_i); #1;
      req0_i = 1'b0;
   endtask

   task automatic test_fixed_prio();
      int n0, n1;
      n0 = 0; n1 = 0;
      do_reset();
      req0_i = 1'b1; we0_i = 1'b0; addr0_i = 4'd1;
      req1_i = 1'b1; we1_i = 1'b0; addr1_i = 4'd2;
      for (int j = 0; j < 9; j++) begin
         @(posedge clk_i); #1;
         if (ack0_o) n0++;
         if (ack1_o) n1++;
      end
      req0_i = 1'b0; req1_i = 1'b0;
      checks++; if (n0 != 3) begin errors++; $display("FAIL fp_ack0: got %0d want 3", n0); end
      checks++; if (n1 != 0) begin errors++; $display("FAIL fp_ack1: got %0d want 0", n1); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_write_read();
`ifdef KT8_ARB_FIXED_PRIO_EN
      test_fixed_prio();
      do_reset();
`else
      test_contention();
      test_cross_port();
      test_reset_mid_write();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/kt8_ram_arb.md
Name: kt8_ram_arb

Overview:
Two-port arbiter/sequencer in front of the KT8 16x8 RAM (async read, posedge write).
Port 0 is the CPU; port 1 is the loader/debug port.
Serialises their requests with a req/ack handshake, drives the single RAM address/data/write-enable set, and returns registered read data.
Default policy is round-robin on contention.

Parameters:
ADDR_W, 4, RAM address width (16 locations)
DATA_W, 8, RAM data width

Ports:
clk_i  in  1  clock, all logic on posedge
rst_i  in  1  reset, synchronous, active-high
req0_i  in  1  port 0 request; held high with fields stable until ack0_o
we0_i  in  1  port 0 write (1) / read (0)
addr0_i  in  ADDR_W  port 0 address
wdata0_i  in  DATA_W  port 0 write data
ack0_o  out  1  port 0 one-cycle completion pulse
rdata0_o  out  DATA_W  port 0 read data, valid while ack0_o=1
req1_i, we1_i, addr1_i, wdata1_i, ack1_o, rdata1_o: same for port 1
ram_addr_o  out  ADDR_W  RAM address
ram_din_o  out  DATA_W  RAM write data
ram_we_o  out  1  RAM write enable
ram_dout_i  in  DATA_W  RAM async read data
busy_o  out  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, ACCESS, ACK.
- Reset (sync, rst_i=1 at posedge): state=IDLE, rr pointer=1 (port 0 wins the first tie), ack0_o=ack1_o=0, rdata0_o=rdata1_o=0, ram_addr_o=0, ram_din_o=0, ram_we_o=0, busy_o=0.
- IDLE: if any req high, grant one; latch its we/addr/wdata plus grant id into internal regs; go to ACCESS. Otherwise stay.
- Arbitration: only one req high -> grant it. Both high -> grant the port not last served (rr pointer); pointer updates to granted port on grant.
- ACCESS (1 cycle):
  - ram_addr_o/ram_din_o come from latched regs.
  - ram_we_o = latched_we & ~rst_i. A reset asserted in ACCESS suppresses the write.
  - On the edge ending ACCESS:
    - Write: the RAM writes.
    - Read: ram_dout_i is captured into the granted port's rdata reg.
    - Granted ack is set. Go to ACK.
- ACK (1 cycle): granted ack_o=1, the other ack=0; go to IDLE.
- Requester samples ack at that edge and may deassert or re-present req from the next cycle.
- Latency: req sampled at edge N -> ack high in cycle N+2. Throughput: 1 access per 3 cycles.
- A req still high in IDLE is a new request; back-to-back requests from one port are allowed.
- Under contention the ports alternate: no starvation.
- rdata of a port holds its last read value until that port's next read completes. Writes do not change rdata.
- Write-then-read of the same address by the other port returns the new value (serialised).
- ram_we_o is 0 in IDLE and ACK. ram_addr_o holds its last value.
- A req dropped before ack is a protocol violation: behaviour undefined, no checking required.
- Reset in any state returns to IDLE at that edge. Any pending ack is cleared; no ack is issued for the aborted access.

Optional Feature:
KT8_ARB_FIXED_PRIO_EN
- Defined: port 0 always wins contention; rr pointer removed; port 1 may starve.
- Undefined: round-robin as above.

Decomposition:
- Shared package kt8_pkg: ADDR_W/DATA_W constants (4/8), FSM state encoding (IDLE=2'd0, ACCESS=2'd1, ACK=2'd2).
- One sub-module, kt8_rr_arb2: combinational 2-way grant from req0/req1 and pointer. Pointer register lives in the parent. Under KT8_ARB_FIXED_PRIO_EN, kt8_rr_arb2 reduces to fixed priority.

Test Plan:
- Reset: hold rst_i 2 cycles -> all outputs 0, busy_o=0, state IDLE.
- Single write then read: port 0 writes 8'hA5 at addr 3, then reads addr 3 -> ram_we_o=1 exactly one cycle (cycle N+1); ack0_o at N+2; read returns rdata0_o=8'hA5 with ack0_o.
- Contention: req0 and req1 both high continuously, reads of addrs 1 and 2 -> acks alternate 0,1,0,1…; every 3 cycles; port 0 first after reset.
- Cross-port coherence: port 1 writes 8'h3C at addr 15 while port 0 has a read of addr 15 pending, port 1 granted first -> port 0 receives 8'h3C.
- Reset mid-write: rst_i high during ACCESS of a write of 8'hFF to addr 7 (prior 8'h00) -> no ram_we_o pulse, no ack; later read of addr 7 returns 8'h00.
- With KT8_ARB_FIXED_PRIO_EN: both reqs held high for 9 cycles -> three ack0_o pulses, no ack1_o.
